wishbone_bus_arbiter: RTL and testbench
=======================================

# wishbone_bus_arbiter

Registered round-robin master arbiter for the shared Wishbone interconnect. It decides which master owns the single master-to-slave path, hands the bus over between transfers, and honours bus lock. A watchdog aborts transfers that no slave terminates. Its one-hot grant drives the interconnect's master mux; the muxed slave termination (ack/err/rty) feeds back into it.

## Interface
- N_MASTER, 4: number of masters, at least 2.
- TIMEOUT, 255: number of stalled strobe cycles before abort; 0 disables the watchdog.
- IDW, $clog2(N_MASTER): owner index width (derived, not overridden).

Ports:
- clk_i  in  1  clock; everything is on the rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- req_cyc_i  in  N_MASTER  per-master wb_cyc_o.
- req_stb_i  in  N_MASTER  per-master wb_stb_o.
- req_lock_i  in  N_MASTER  per-master wb_lock_o.
- bus_ack_i  in  1  muxed slave ack.
- bus_err_i  in  1  muxed slave err.
- bus_rty_i  in  1  muxed slave rty.
- gnt_o  out  N_MASTER  registered one-hot grant, or all zeros.
- owner_o  out  IDW  index of the granted master; 0 when idle.
- bus_busy_o  out  1  high in any state except IDLE.
- tmo_err_o  out  1  one-cycle error pulse to the owner on timeout; ORed into the master err by the interconnect.

## Operation
- State machine states: IDLE, OWNED, ABORT.
- Round-robin pointer ptr (IDW bits).
- Arbitration picks the first master with req_cyc_i=1, searching from ptr upward and wrapping modulo N_MASTER.
- On every new grant to winner w, ptr <= (w+1) mod N_MASTER.
- IDLE:
  - gnt_o=0.
  - If any req_cyc_i is high: arbitrate, go to OWNED, and register the grant.
- OWNED, owner o.
  - A termination is (bus_ack_i|bus_err_i|bus_rty_i) while req_stb_i[o]=1. Termination inputs are ignored otherwise and in IDLE.
  - If req_cyc_i[o]=0: arbitrate among the remaining requesters. If a winner exists, grant it (OWNED); otherwise go to IDLE. This check takes priority over a simultaneous termination.
  - Else, on a termination with req_lock_i[o]=0 and at least one other req_cyc_i high: preempt. Arbitrate with o masked out and grant the winner.
  - Else, on a termination with req_lock_i[o]=1: keep the owner. Lock is sampled in the terminating cycle.
  - Watchdog counter, width $clog2(TIMEOUT+1):
    - Increments each OWNED cycle in which req_stb_i[o]=1 and no termination occurs.
    - Clears on a termination, when req_stb_i[o]=0, and on an owner change.
    - When the counter equals TIMEOUT-1 and it increments (no termination that cycle): go to ABORT.
  - Lock does not suppress the watchdog.
- ABORT:
  - Lasts exactly one cycle.
  - tmo_err_o=1 and gnt_o still shows the owner.
  - Next state: arbitrate with the old owner masked out. Grant the winner (OWNED), or go to IDLE if there is none.
  - The old owner may re-request afterwards.
- Outputs:
  - gnt_o and owner_o are registered and change together.
  - At most one bit of gnt_o is ever set.
- Reset (rstn_i low, any time, including mid-transfer):
  - Immediately: gnt_o=0, owner_o=0, bus_busy_o=0, tmo_err_o=0.
  - State IDLE; ptr=0; counter=0.

## Timing
- Grant latency: req_cyc_i rises in IDLE at cycle t; gnt_o is set at t+1.
- Handoff has no bubble:
  - Owner drops cyc at t, or terminates and is preempted at t.
  - At t+1 the new gnt_o is set and the old bit is clear.
- Timeout:
  - req_stb_i[o] is high from cycle s with no termination.
  - tmo_err_o=1 during cycle s+TIMEOUT.
  - gnt_o moves or clears at s+TIMEOUT+1.
  - A termination in cycle s+TIMEOUT-1 wins: no abort.
- Counter wrap is impossible; it saturates at the ABORT transition.
- Lock released and a new request in the same cycle as a termination: preemption occurs.

## Test plan
- Reset: rstn_i=0 with req_cyc_i=4'b1111 → all outputs 0. Release with req_cyc_i=0 → gnt_o stays 0 and bus_busy_o=0.
- Single master:
  - req_cyc_i=4'b0100 at t0 → gnt_o=4'b0100 and owner_o=2 at t1.
  - Cyc dropped at t3 → gnt_o=0 at t4.
- Fairness: req_cyc_i=req_stb_i=4'b1111 held, ack asserted one cycle per granted cycle, lock=0 → grant sequence 0001, 0010, 0100, 1000, 0001.
- Lock (req_cyc_i=4'b0011, master1 owns with lock=1):
  - Three acks → gnt_o stays 4'b0010.
  - Lock cleared, next ack → gnt_o=4'b0001 the following cycle.
- Timeout (TIMEOUT=8, master3 owns, stb high from cycle s, no ack, master0 requesting):
  - tmo_err_o is a single pulse in cycle s+8.
  - gnt_o=4'b0001 at s+9.
  - An ack at s+7 instead → no pulse.
- Asynchronous reset while OWNED: rstn_i falls mid-cycle → gnt_o=0 before the next clock edge. After release with req_cyc_i=4'b1010 → master1 is granted (ptr=0).

Source files
------------

// File: rtl/wishbone_bus_arbiter.sv
// Registered round-robin master arbiter for a shared Wishbone interconnect.
// Issues a one-hot grant, hands the bus over between transfers, honours bus
// lock, and aborts transfers that no slave terminates via a watchdog.
module wishbone_bus_arbiter #(
  parameter int N_MASTER = 4,
  parameter int TIMEOUT  = 255,
  parameter int IDW      = $clog2(N_MASTER)
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [N_MASTER-1:0] req_cyc_i,
  input  logic [N_MASTER-1:0] req_stb_i,
  input  logic [N_MASTER-1:0] req_lock_i,
  input  logic                bus_ack_i,
  input  logic                bus_err_i,
  input  logic                bus_rty_i,
  output logic [N_MASTER-1:0] gnt_o,
  output logic [IDW-1:0]      owner_o,
  output logic                bus_busy_o,
  output logic                tmo_err_o
);

  localparam int unsigned NM = N_MASTER;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, OWNED, ABORT} state_t;

  state_t              state, state_nxt;
  logic [N_MASTER-1:0] gnt_nxt;
  logic [IDW-1:0]      owner_nxt;
  logic [IDW-1:0]      ptr, ptr_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [N_MASTER-1:0] cand;
  logic [IDW-1:0]      win;
  logic                win_vld;
  int unsigned         arb_idx;
  logic                term;
  logic                do_grant, do_idle;

  // Round-robin search from ptr; the current owner is masked out whenever the
  // bus is held, which covers cyc drop, preemption and post-abort handoff alike.
  always_comb begin
    cand = req_cyc_i;
    if (state != IDLE) cand[owner_o] = 1'b0;
    win     = '0;
    win_vld = 1'b0;
    arb_idx = 0;
    for (int unsigned i = 0; i < NM; i++) begin
      arb_idx = 32'(ptr) + i;
      if (arb_idx >= NM) arb_idx = arb_idx - NM;
      if (!win_vld && cand[arb_idx[IDW-1:0]]) begin
        win     = arb_idx[IDW-1:0];
        win_vld = 1'b1;
      end
    end
  end

  assign term = (bus_ack_i | bus_err_i | bus_rty_i) & req_stb_i[owner_o];

  // Next-state, grant, pointer and watchdog decisions.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_o;
    owner_nxt = owner_o;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    do_grant  = 1'b0;
    do_idle   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt  = '0;
        do_grant = win_vld;
      end
      OWNED: begin
        if (!req_cyc_i[owner_o]) begin
          cnt_nxt  = '0;
          do_grant = win_vld;
          do_idle  = !win_vld;
        end else if (term) begin
          cnt_nxt  = '0;
          do_grant = !req_lock_i[owner_o] && win_vld;
        end else if (req_stb_i[owner_o]) begin
          if (TIMEOUT == 0) cnt_nxt = '0;
          else if (cnt == CNT_LAST) state_nxt = ABORT;
          else cnt_nxt = cnt + CW'(1);
        end else begin
          cnt_nxt = '0;
        end
      end
      ABORT: begin
        cnt_nxt  = '0;
        do_grant = win_vld;
        do_idle  = !win_vld;
      end
      default: begin
        state_nxt = IDLE;
        do_idle   = 1'b1;
      end
    endcase
    if (do_grant) begin
      state_nxt    = OWNED;
      gnt_nxt      = '0;
      gnt_nxt[win] = 1'b1;
      owner_nxt    = win;
      cnt_nxt      = '0;
      ptr_nxt      = (win == IDW'(N_MASTER - 1)) ? '0 : win + IDW'(1);
    end else if (do_idle) begin
      state_nxt = IDLE;
      gnt_nxt   = '0;
      owner_nxt = '0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state   <= IDLE;
      gnt_o   <= '0;
      owner_o <= '0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      gnt_o   <= gnt_nxt;
      owner_o <= owner_nxt;
      ptr     <= ptr_nxt;
      cnt     <= cnt_nxt;
    end
  end

  assign bus_busy_o = (state != IDLE);
  assign tmo_err_o  = (state == ABORT);

endmodule

// File: tb/tb_wishbone_bus_arbiter.sv
// Self-checking bench for wishbone_bus_arbiter: directed scenarios plus
// randomized traffic compared against a behavioural model of the arbiter.
module tb_wishbone_bus_arbiter;

  localparam int N   = 4;
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] cyc, stb, lock;
  logic       ack, err, rty;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       busy, tmo;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model: owner -1 means bus idle.
  int m_owner, m_ptr, m_cnt;
  bit m_abort;

  wishbone_bus_arbiter #(.N_MASTER(N), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .req_cyc_i(cyc), .req_stb_i(stb), .req_lock_i(lock),
    .bus_ack_i(ack), .bus_err_i(err), .bus_rty_i(rty),
    .gnt_o(gnt), .owner_o(owner), .bus_busy_o(busy), .tmo_err_o(tmo)
  );

  always #5 clk = ~clk;

  function automatic int pick(int excl);
    for (int k = 0; k < N; k++) begin
      int m;
      m = (m_ptr + k) % N;
      if (cyc[m] && m != excl) return m;
    end
    return -1;
  endfunction

  task automatic model_take(int w);
    m_cnt = 0;
    if (w >= 0) begin
      m_owner = w;
      m_ptr   = (w + 1) % N;
    end else begin
      m_owner = -1;
    end
  endtask

  task automatic model_step();
    int o;
    bit t;
    if (!rstn) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_abort = 0;
    end else if (m_abort) begin
      m_abort = 0;
      model_take(pick(m_owner));
    end else if (m_owner < 0) begin
      model_take(pick(-1));
    end else begin
      o = m_owner;
      t = (ack || err || rty) && stb[o];
      if (!cyc[o]) model_take(pick(o));
      else if (t) begin
        m_cnt = 0;
        if (!lock[o] && pick(o) >= 0) model_take(pick(o));
      end else if (stb[o]) begin
        if (m_cnt == TMO - 1) m_abort = 1;
        else m_cnt++;
      end else m_cnt = 0;
    end
  endtask

  function automatic logic [3:0] exp_gnt();
    return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    cyc = '0; stb = '0; lock = '0; ack = 1'b0; err = 1'b0; rty = 1'b0;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    clear_inputs();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    clear_inputs();
    cyc = 4'b1111; stb = 4'b1111;
    tick();
    n_assert++;
    if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    n_assert++;
    if (owner !== 2'd0) begin n_fail++; $display("FAIL reset_owner: got %0d expected 0", owner); end
    n_assert++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_assert++;
    if (tmo !== 1'b0) begin n_fail++; $display("FAIL reset_tmo: got %b expected 0", tmo); end
    rstn = 1'b1;
    cyc  = '0; stb = '0;
    tick();
    n_assert++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: got gnt=%b busy=%b expected 0000/0", gnt, busy);
    end
  endtask

  task automatic test_single();
    apply_reset();
    cyc = 4'b0100;
    tick();
    n_assert++;
    if (gnt !== 4'b0100 || owner !== 2'd2 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_grant: got gnt=%b owner=%0d busy=%b expected 0100/2/1", gnt, owner, busy);
    end
    tick();
    tick();
    n_assert++;
    if (gnt !== 4'b0100) begin n_fail++; $display("FAIL single_hold: got %b expected 0100", gnt); end
    cyc = 4'b0000;
    tick();
    n_assert++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_release: got gnt=%b busy=%b expected 0000/0", gnt, busy);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] seq [5];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
    apply_reset();
    cyc = 4'b1111; stb = 4'b1111; ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_assert++;
      if (gnt !== seq[i]) begin n_fail++; $display("FAIL fair_%0d: got %b expected %b", i, gnt, seq[i]); end
    end
    clear_inputs();
  endtask

  task automatic test_lock();
    apply_reset();
    cyc = 4'b0010;
    tick();
    cyc = 4'b0011; stb = 4'b0010; lock = 4'b0010; ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_assert++;
      if (gnt !== 4'b0010) begin n_fail++; $display("FAIL lock_hold_%0d: got %b expected 0010", i, gnt); end
    end
    lock = 4'b0000;
    tick();
    n_assert++;
    if (gnt !== 4'b0001) begin n_fail++; $display("FAIL lock_release: got %b expected 0001", gnt); end
    clear_inputs();
  endtask

  task automatic test_timeout();
    int pulses;
    apply_reset();
    cyc = 4'b1000;
    tick();
    cyc = 4'b1001; stb = 4'b1000;
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (tmo === 1'b1) pulses++;
      n_assert++;
      if (gnt !== 4'b1000) begin n_fail++; $display("FAIL tmo_owner_s%0d: got %b expected 1000", k, gnt); end
    end
    n_assert++;
    if (tmo !== 1'b1) begin n_fail++; $display("FAIL tmo_pulse_s8: got %b expected 1", tmo); end
    tick();
    if (tmo === 1'b1) pulses++;
    n_assert++;
    if (gnt !== 4'b0001) begin n_fail++; $display("FAIL tmo_handoff: got %b expected 0001", gnt); end
    n_assert++;
    if (pulses != 1) begin n_fail++; $display("FAIL tmo_pulse_count: got %0d expected 1", pulses); end

    apply_reset();
    cyc = 4'b1000;
    tick();
    cyc = 4'b1001; stb = 4'b1000;
    pulses = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (tmo === 1'b1) pulses++;
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    if (tmo === 1'b1) pulses++;
    n_assert++;
    if (gnt !== 4'b0001) begin n_fail++; $display("FAIL tmo_late_ack_gnt: got %b expected 0001", gnt); end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (tmo === 1'b1) pulses++;
    end
    n_assert++;
    if (pulses != 0) begin n_fail++; $display("FAIL tmo_late_ack_pulse: got %0d expected 0", pulses); end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    apply_reset();
    cyc = 4'b0100; stb = 4'b0100;
    tick();
    #2 rstn = 1'b0;
    #1;
    n_assert++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0) begin
      n_fail++; $display("FAIL async_reset: got gnt=%b owner=%0d busy=%b expected 0000/0/0", gnt, owner, busy);
    end
    tick();
    rstn = 1'b1;
    cyc = 4'b1010; stb = 4'b0000;
    tick();
    n_assert++;
    if (gnt !== 4'b0010 || owner !== 2'd1) begin
      n_fail++; $display("FAIL async_regrant: got gnt=%b owner=%0d expected 0010/1", gnt, owner);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      cyc  = cyc ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      stb  = cyc & 4'($urandom);
      lock = 4'($urandom);
      ack  = ($urandom_range(0, 9) == 0);
      err  = ($urandom_range(0, 39) == 0);
      rty  = ($urandom_range(0, 39) == 0);
      tick();
      n_assert++;
      if (gnt !== exp_gnt() || owner !== 2'((m_owner < 0) ? 0 : m_owner) ||
          busy !== (m_owner >= 0) || tmo !== m_abort) begin
        n_fail++;
        $display("FAIL random_%0d: got gnt=%b owner=%0d busy=%b tmo=%b expected gnt=%b owner=%0d busy=%b tmo=%b",
                 i, gnt, owner, busy, tmo, exp_gnt(), (m_owner < 0) ? 0 : m_owner, m_owner >= 0, m_abort);
      end
    end
    clear_inputs();
  endtask

  initial begin
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_abort = 0;
    test_reset();
    test_single();
    test_fairness();
    test_lock();
    test_timeout();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
